// File: rtl/rst_sequencer.sv
// Power-up/reset sequencer: releases subsystem resets in index order,
// waits for each ready, retries on timeout and latches a fault.
module rst_sequencer #(
  parameter int NUM_STAGES = 3,
  parameter int STAGE_DLY  = 16,
  parameter int TIMEOUT    = 1024,
  parameter int MAX_RETRY  = 3
) (
  input  logic                  clk,
  input  logic                  RST_n,
  input  logic                  soft_rst_req,
  input  logic [NUM_STAGES-1:0] stage_rdy,
  output logic [NUM_STAGES-1:0] stage_rst_n,
  output logic                  all_rdy,
  output logic                  seq_fault,
  output logic [1:0]            retry_cnt
);

  localparam int DW = $clog2(STAGE_DLY + 1);
  localparam int TW = $clog2(TIMEOUT);
  localparam int IW = $clog2(NUM_STAGES + 1);

  localparam logic [DW-1:0] DLY_LAST  = DW'(STAGE_DLY - 1);
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_STAGES - 1);
  localparam logic [1:0]    RETRY_MAX = 2'(MAX_RETRY);

  typedef enum logic [2:0] {
    HOLD,
    DELAY,
    WAIT_RDY,
    RUN,
    FAULT
  } state_t;

  state_t                  state;
  logic                    sync_q1;
  logic                    rst_sync;
  logic [IW-1:0]           idx;
  logic [DW-1:0]           dcnt;
  logic [TW-1:0]           tcnt;
  logic [NUM_STAGES-1:0]   sel;
  logic                    rdy_cur;

  // Asserts asynchronously, deasserts on the 2nd edge after RST_n rises
  always_ff @(posedge clk or negedge RST_n) begin
    if (!RST_n) begin
      sync_q1  <= 1'b0;
      rst_sync <= 1'b0;
    end else begin
      sync_q1  <= 1'b1;
      rst_sync <= sync_q1;
    end
  end

  assign sel     = NUM_STAGES'(1) << idx;
  assign rdy_cur = |(stage_rdy & sel);

  always_ff @(posedge clk or negedge RST_n) begin
    if (!RST_n) begin
      state       <= HOLD;
      stage_rst_n <= '0;
      all_rdy     <= 1'b0;
      seq_fault   <= 1'b0;
      retry_cnt   <= 2'd0;
      idx         <= '0;
      dcnt        <= '0;
      tcnt        <= '0;
    end else if (soft_rst_req) begin
      state       <= HOLD;
      stage_rst_n <= '0;
      all_rdy     <= 1'b0;
      seq_fault   <= 1'b0;
      retry_cnt   <= 2'd0;
      idx         <= '0;
      dcnt        <= '0;
      tcnt        <= '0;
    end else begin
      unique case (state)
        HOLD: begin
          stage_rst_n <= '0;
          all_rdy     <= 1'b0;
          idx         <= '0;
          dcnt        <= '0;
          if (rst_sync) begin
            state <= DELAY;
          end
        end
        DELAY: begin
          if (dcnt == DLY_LAST) begin
            stage_rst_n <= stage_rst_n | sel;
            tcnt        <= '0;
            state       <= WAIT_RDY;
          end else begin
            dcnt <= dcnt + DW'(1);
          end
        end
        WAIT_RDY: begin
          if (rdy_cur) begin
            if (idx == IDX_LAST) begin
              all_rdy <= 1'b1;
              state   <= RUN;
            end else begin
              idx   <= idx + IW'(1);
              dcnt  <= '0;
              state <= DELAY;
            end
          end else if (tcnt == TMO_LAST) begin
            stage_rst_n <= '0;
            if (retry_cnt < RETRY_MAX) begin
              retry_cnt <= retry_cnt + 2'd1;
              state     <= HOLD;
            end else begin
              seq_fault <= 1'b1;
              state     <= FAULT;
            end
          end else begin
            tcnt <= tcnt + TW'(1);
          end
        end
        // Ready drops in RUN are left to downstream
        RUN: begin
          stage_rst_n <= '1;
          all_rdy     <= 1'b1;
        end
        FAULT: begin
          stage_rst_n <= '0;
          all_rdy     <= 1'b0;
          seq_fault   <= 1'b1;
        end
        default: begin
          state <= HOLD;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rst_sequencer.sv
// Scoreboard bench for rst_sequencer: expected output transitions are
// queued with their edge number and matched as the outputs change.
module tb_rst_sequencer;

  logic       clk = 1'b0;
  logic       RST_n = 1'b0;
  logic       soft_rst_req = 1'b0;
  logic [2:0] stage_rdy = 3'b111;
  logic [2:0] stage_rst_n;
  logic       all_rdy;
  logic       seq_fault;
  logic [1:0] retry_cnt;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit mon_en = 1'b0;

  typedef struct {
    int         cyc;
    logic [6:0] out;
  } ev_t;

  ev_t        q[$];
  logic [6:0] prev;

  rst_sequencer dut (
    .clk          (clk),
    .RST_n        (RST_n),
    .soft_rst_req (soft_rst_req),
    .stage_rdy    (stage_rdy),
    .stage_rst_n  (stage_rst_n),
    .all_rdy      (all_rdy),
    .seq_fault    (seq_fault),
    .retry_cnt    (retry_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h",
               tag, cyc, obs, exp);
    end
  endtask

  function automatic logic [6:0] pk(input logic [1:0] r,
                                    input logic f,
                                    input logic a,
                                    input logic [2:0] s);
    return {r, f, a, s};
  endfunction

  function automatic logic [6:0] outs();
    return {retry_cnt, seq_fault, all_rdy, stage_rst_n};
  endfunction

  task automatic exp_ev(input int c, input logic [6:0] o);
    ev_t e;
    e.cyc = c;
    e.out = o;
    q.push_back(e);
  endtask

  always @(negedge clk) begin
    logic [6:0] cur;
    ev_t e;
    if (mon_en) begin
      cur = outs();
      if (cur !== prev) begin
        chk("sb_pending", 32'(q.size() != 0), 32'd1);
        if (q.size() != 0) begin
          e = q.pop_front();
          chk("ev_cyc", 32'(cyc), 32'(e.cyc));
          chk("ev_out", 32'(cur), 32'(e.out));
        end
        prev = cur;
      end
    end
  end

  task automatic wait_drain(input int budget);
    int n = 0;
    while (q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    chk("sb_drain", 32'(q.size()), 32'd0);
    q.delete();
  endtask

  task automatic soft_pulse(input int len, output int c);
    @(negedge clk);
    c = cyc;
    soft_rst_req = 1'b1;
    repeat (len) @(negedge clk);
    soft_rst_req = 1'b0;
  endtask

  task automatic exp_full(input int b);
    exp_ev(b + 19, pk(2'd0, 1'b0, 1'b0, 3'b001));
    exp_ev(b + 36, pk(2'd0, 1'b0, 1'b0, 3'b011));
    exp_ev(b + 53, pk(2'd0, 1'b0, 1'b0, 3'b111));
    exp_ev(b + 54, pk(2'd0, 1'b0, 1'b1, 3'b111));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int c;
    int b;
    int r;
    repeat (3) @(negedge clk);
    chk("rst_stage_rst_n", 32'(stage_rst_n), 32'd0);
    chk("rst_all_rdy", 32'(all_rdy), 32'd0);
    chk("rst_seq_fault", 32'(seq_fault), 32'd0);
    chk("rst_retry_cnt", 32'(retry_cnt), 32'd0);
    prev   = outs();
    mon_en = 1'b1;

    // Power-up: edge 1 follows RST_n release
    b = cyc;
    RST_n = 1'b1;
    exp_full(b - 1 + 1);
    wait_drain(120);

    // Soft reset held 5 cycles in RUN
    @(negedge clk);
    c = cyc;
    exp_ev(c + 1, 7'd0);
    exp_ev(c + 22, pk(2'd0, 1'b0, 1'b0, 3'b001));
    exp_ev(c + 39, pk(2'd0, 1'b0, 1'b0, 3'b011));
    exp_ev(c + 56, pk(2'd0, 1'b0, 1'b0, 3'b111));
    exp_ev(c + 57, pk(2'd0, 1'b0, 1'b1, 3'b111));
    soft_rst_req = 1'b1;
    repeat (5) @(negedge clk);
    soft_rst_req = 1'b0;
    wait_drain(120);

    // Ready of stage 1 delayed by 100 cycles
    stage_rdy = 3'b101;
    @(negedge clk);
    c = cyc;
    exp_ev(c + 1, 7'd0);
    exp_ev(c + 18, pk(2'd0, 1'b0, 1'b0, 3'b001));
    exp_ev(c + 35, pk(2'd0, 1'b0, 1'b0, 3'b011));
    soft_rst_req = 1'b1;
    @(negedge clk);
    soft_rst_req = 1'b0;
    wait_drain(80);
    while (cyc < c + 135) @(negedge clk);
    exp_ev(cyc + 17, pk(2'd0, 1'b0, 1'b0, 3'b111));
    exp_ev(cyc + 18, pk(2'd0, 1'b0, 1'b1, 3'b111));
    stage_rdy = 3'b111;
    wait_drain(60);

    // Timeout and retries, ending in FAULT
    stage_rdy = 3'b000;
    @(negedge clk);
    c = cyc;
    exp_ev(c + 1, 7'd0);
    r = c + 18;
    for (int k = 0; k < 4; k++) begin
      exp_ev(r, pk(2'(k), 1'b0, 1'b0, 3'b001));
      if (k < 3)
        exp_ev(r + 1024, pk(2'(k + 1), 1'b0, 1'b0, 3'b000));
      else
        exp_ev(r + 1024, pk(2'd3, 1'b1, 1'b0, 3'b000));
      r += 1041;
    end
    soft_rst_req = 1'b1;
    @(negedge clk);
    soft_rst_req = 1'b0;
    wait_drain(4300);
    repeat (40) @(negedge clk);
    chk("fault_held", 32'(seq_fault), 32'd1);
    chk("fault_rst_n", 32'(stage_rst_n), 32'd0);

    // Recovery from FAULT with a one-cycle soft reset
    stage_rdy = 3'b111;
    @(negedge clk);
    c = cyc;
    exp_ev(c + 1, 7'd0);
    exp_ev(c + 18, pk(2'd0, 1'b0, 1'b0, 3'b001));
    exp_ev(c + 35, pk(2'd0, 1'b0, 1'b0, 3'b011));
    exp_ev(c + 52, pk(2'd0, 1'b0, 1'b0, 3'b111));
    exp_ev(c + 53, pk(2'd0, 1'b0, 1'b1, 3'b111));
    soft_rst_req = 1'b1;
    @(negedge clk);
    soft_rst_req = 1'b0;
    wait_drain(120);

    // Async reset while waiting on stage 1
    stage_rdy = 3'b101;
    @(negedge clk);
    c = cyc;
    exp_ev(c + 1, 7'd0);
    exp_ev(c + 18, pk(2'd0, 1'b0, 1'b0, 3'b001));
    exp_ev(c + 35, pk(2'd0, 1'b0, 1'b0, 3'b011));
    soft_rst_req = 1'b1;
    @(negedge clk);
    soft_rst_req = 1'b0;
    wait_drain(80);
    repeat (5) @(negedge clk);
    @(posedge clk);
    #2;
    exp_ev(cyc, 7'd0);
    RST_n = 1'b0;
    #1;
    chk("async_rst_n", 32'(stage_rst_n), 32'd0);
    chk("async_all_rdy", 32'(all_rdy), 32'd0);
    repeat (3) @(negedge clk);
    stage_rdy = 3'b111;
    b = cyc;
    RST_n = 1'b1;
    exp_full(b);
    wait_drain(120);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
